matvec_x_loader: RTL and testbench

//   Upstream feeder for matvec_mul. Accepts the input vector x one element
//   per handshake on a valid/ready stream and packs C elements into the

---
 rtl/matvec_x_loader.sv | 103 ++++++++++
 tb/tb_matvec_x_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_x_loader.sv
// Stream-to-vector packer feeding matvec_mul: collects C elements per vector,
// issues them as one parallel x word and replays the issue strobe as y_valid.
module matvec_x_loader #(
  parameter int C   = 5,
  parameter int W_X = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W_X-1:0]          s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    cen,
  output logic [C-1:0][W_X-1:0]   x,
  output logic                    x_valid,
  output logic                    y_valid,
  output logic                    err_len
);

  localparam int LATENCY = $clog2(C) + 1;
  localparam int CW      = $clog2(C);
  localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);

  // Stream handshake: an element moves only on a cycle where s_valid and
  // s_ready are both high; s_ready depends on state only, never on s_valid.
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [C-1:0][W_X-1:0]   buf_q, buf_d;
  logic [C-1:0][W_X-1:0]   x_q, x_d;
  logic                    x_valid_q, x_valid_d;
  logic                    err_q, err_d;
  logic [LATENCY-1:0]      dly_q;
  logic                    xfer;

  assign xfer = s_valid && (state_q == FILL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    x_d       = x_q;
    x_valid_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      FILL: begin
        if (xfer) begin
          buf_d[cnt_q] = s_data;
          cnt_d        = cnt_q + 1'b1;
          // Either end condition closes the vector; any disagreement between
          // them is a length error. Unfilled slots are already zero.
          if ((cnt_q == CNT_LAST) || s_last) begin
            state_d = ISSUE;
            err_d   = !((cnt_q == CNT_LAST) && s_last);
          end
        end
      end
      ISSUE: begin
        x_d       = buf_q;
        x_valid_d = 1'b1;
        buf_d     = '0;
        cnt_d     = '0;
        state_d   = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      buf_q     <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      err_q     <= 1'b0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      err_q     <= err_d;
      // Mirrors the multiplier pipeline so y_valid lines up with its y.
      dly_q     <= {dly_q[LATENCY-2:0], x_valid_q};
    end
  end

  assign s_ready = (state_q == FILL);
  assign cen     = 1'b1;
  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign err_len = err_q;
  assign y_valid = dly_q[LATENCY-1];

endmodule

// File: tb/tb_matvec_x_loader.sv
// Bench for matvec_x_loader: table of vectors driven through the stream port,
// issued words checked against an expected queue, plus reset corner cases.
module tb_matvec_x_loader;

  localparam int C   = 5;
  localparam int W_X = 3;
  localparam int XW  = C * W_X;
  localparam int LAT = 4;

  logic                  clk;
  logic                  rst;
  logic [W_X-1:0]        s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  cen;
  logic [C-1:0][W_X-1:0] x;
  logic                  x_valid;
  logic                  y_valid;
  logic                  err_len;

  matvec_x_loader #(.C(C), .W_X(W_X)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .cen     (cen),
    .x       (x),
    .x_valid (x_valid),
    .y_valid (y_valid),
    .err_len (err_len)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          total;
  int          bad;
  int          cyc;
  int          y_cnt;
  logic [XW-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            y_q[$];
  int            xv_t[$];
  logic          prev_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [XW-1:0] pk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4);
    return {3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
  endfunction

  // Monitor samples just after each rising edge; drivers act on falling edges.
  initial begin
    cyc      = 0;
    y_cnt    = 0;
    prev_err = 1'b0;
    forever begin
      logic [XW-1:0] e;
      logic          ee;
      logic          exp_y;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        y_q.delete();
        prev_err = 1'b0;
      end else begin
        if (x_valid) begin
          xv_t.push_back(cyc);
          y_q.push_back(cyc + LAT);
          if (exp_q.size() == 0) begin
            chk("x_valid_unexpected", 32'(x_valid), 32'd0);
          end else begin
            e  = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            chk("x_vec", 32'(x), 32'(e));
            chk("err_len", 32'(prev_err), 32'(ee));
          end
        end else if (prev_err) begin
          chk("err_len_stray", 32'(prev_err), 32'd0);
        end
        exp_y = (y_q.size() > 0) && (y_q[0] == cyc);
        if (y_valid || exp_y) begin
          chk("y_valid", 32'(y_valid), 32'(exp_y));
          if (exp_y) void'(y_q.pop_front());
        end
        if (y_valid) y_cnt++;
        prev_err = err_len;
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [XW-1:0] d;
    int            n;
    logic          last;
    logic [XW-1:0] exp_x;
    logic          exp_err;
    int            gap;
  } rec_t;

  rec_t tbl[9];

  task automatic send_elem(input logic [W_X-1:0] d, input logic last, input int gap);
    int t;
    for (int g = 0; g < 4 && $urandom_range(0, 99) < gap; g++) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_vec(input rec_t r);
    exp_q.push_back(r.exp_x);
    exp_err_q.push_back(r.exp_err);
    for (int k = 0; k < r.n; k++)
      send_elem(r.d[k*W_X +: W_X], r.last && (k == r.n - 1), r.gap);
  endtask

  task automatic drain();
    int t;
    s_valid = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || y_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || y_q.size() != 0)
      chk("drain_timeout", 32'(exp_q.size() + y_q.size()), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int y0;
    int t;
    total = 0;
    bad   = 0;

    tbl[0] = '{pk(1, 2, 3, -1, -4),  5, 1'b1, pk(1, 2, 3, -1, -4),  1'b0, 0};
    tbl[1] = '{pk(3, -3, 0, 1, 2),   5, 1'b1, pk(3, -3, 0, 1, 2),   1'b0, 0};
    tbl[2] = '{pk(-1, -2, -3, -4, 0), 5, 1'b1, pk(-1, -2, -3, -4, 0), 1'b0, 0};
    tbl[3] = '{pk(2, 3, 1, 1, 1),    2, 1'b1, pk(2, 3, 0, 0, 0),    1'b1, 0};
    tbl[4] = '{pk(1, 1, 1, 1, 1),    5, 1'b0, pk(1, 1, 1, 1, 1),    1'b1, 0};
    tbl[5] = '{pk(3, 2, 1, 0, -1),   5, 1'b1, pk(3, 2, 1, 0, -1),   1'b0, 0};
    tbl[6] = '{pk(1, 2, 3, -1, -4),  5, 1'b1, pk(1, 2, 3, -1, -4),  1'b0, 50};
    tbl[7] = '{pk(-4, 3, -2, 1, 0),  5, 1'b1, pk(-4, 3, -2, 1, 0),  1'b0, 50};
    tbl[8] = '{pk(-1, 2, 2, 2, 2),   1, 1'b1, pk(-1, 0, 0, 0, 0),   1'b1, 0};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("cen", 32'(cen), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 9; i++) send_vec(tbl[i]);
    drain();
    chk("issue_spacing_01", 32'(xv_t[1] - xv_t[0]), 32'd6);
    chk("issue_spacing_12", 32'(xv_t[2] - xv_t[1]), 32'd6);
    repeat (5) @(negedge clk);
    chk("x_hold", 32'(x), 32'(tbl[8].exp_x));

    // Reset in the middle of filling: only the fresh vector may appear.
    for (int k = 0; k < 3; k++) send_elem(3'd3, 1'b0, 0);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_s_ready", 32'(s_ready), 32'd1);
    send_vec('{pk(1, -1, 2, -2, 0), 5, 1'b1, pk(1, -1, 2, -2, 0), 1'b0, 0});
    drain();

    // Reset two cycles after issue: the pending y_valid must be dropped.
    send_vec('{pk(2, 2, -3, 1, -1), 5, 1'b1, pk(2, 2, -3, 1, -1), 1'b0, 0});
    s_valid = 1'b0;
    t = 0;
    while (!x_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("x_valid_seen", 32'(x_valid), 32'd1);
    y0 = y_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("y_dropped_after_rst", 32'(y_cnt), 32'(y0));
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
